fpaddsub_stream_ctrl: RTL

Issue and collect controller for the 9-stage fixed-latency FP add/sub pipeline. The pipeline has no handshake or valid tracking. This block accepts operand transactions over a valid/ready stream and drives the pipeline inputs. It tracks in-flight operations with a valid/tag delay line, captures returning result+flags into a FIFO, and presents them on a downstream valid/ready stream. Credit-based issue guarantees no result is ever dropped, because the pipeline cannot stall.

---
 rtl/fpaddsub_stream_ctrl_if.sv | 28 ++
 rtl/fpaddsub_stream_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fpaddsub_stream_ctrl_if.sv
// Operand and result streams of the FP add/sub issue/collect controller.
// The controller takes the slave view: it consumes operands and produces results.
interface fpaddsub_stream_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_a;
  logic [31:0]      s_b;
  logic             s_op;
  logic [TAG_W-1:0] s_tag;

  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_result;
  logic [4:0]       m_flags;
  logic [TAG_W-1:0] m_tag;

  modport slave (
    input  s_valid, s_a, s_b, s_op, s_tag, m_ready,
    output s_ready, m_valid, m_result, m_flags, m_tag
  );

  modport master (
    output s_valid, s_a, s_b, s_op, s_tag, m_ready,
    input  s_ready, m_valid, m_result, m_flags, m_tag
  );
endinterface

// File: rtl/fpaddsub_stream_ctrl.sv
// Issue/collect controller wrapped around a fixed-latency, non-stallable FP add/sub pipeline.
// Credit-based issue ensures every in-flight result always has a free slot in the result FIFO.
module fpaddsub_stream_ctrl #(
  parameter int LATENCY = 9,
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fpaddsub_stream_ctrl_if.slave      strm,
  output logic [31:0]                fpu_a,
  output logic [31:0]                fpu_b,
  output logic                       fpu_operation,
  input  logic [31:0]                fpu_result,
  input  logic [4:0]                 fpu_flags,
  output logic [4:0]                 flag_acc,
  input  logic                       flag_clr,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int NS = LATENCY + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

  logic [31:0]      fpu_a_q, fpu_b_q;
  logic             fpu_op_q;
  logic [NS-1:0]    vld_q;
  logic [TAG_W-1:0] tag_q [NS];

  logic [31:0]      res_mem  [DEPTH];
  logic [4:0]       flag_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [OW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             ready_q, ready_d;
  logic [4:0]       flag_acc_q, flag_acc_d;

  logic             accept, pop, wr, head_valid;
  logic [4:0]       head_flags;

  assign head_valid = (cnt_q != '0);
  assign accept     = strm.s_valid & ready_q;
  assign pop        = head_valid & strm.m_ready;
  assign wr         = vld_q[NS-1];
  assign head_flags = head_valid ? flag_mem[rptr_q] : 5'd0;

  // Net occupancy only changes on accept vs pop; a delay-line exit just moves an entry into the FIFO.
  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + OW'(1);
    else if (!accept && pop) occ_d = occ_q - OW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr && !pop)      cnt_d = cnt_q + OW'(1);
    else if (!wr && pop) cnt_d = cnt_q - OW'(1);
  end

  assign ready_d = (occ_d < DEPTH_W);

  always_comb begin
    flag_acc_d = flag_acc_q;
    if (flag_clr && pop) flag_acc_d = head_flags;
    else if (flag_clr)   flag_acc_d = 5'd0;
    else if (pop)        flag_acc_d = flag_acc_q | head_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < NS; i++) tag_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      occ_q      <= '0;
      ready_q    <= 1'b0;
      flag_acc_q <= '0;
    end else begin
      // Idle cycles feed zeros so the adder computes a harmless +0 + +0 bubble.
      fpu_a_q  <= accept ? strm.s_a  : 32'd0;
      fpu_b_q  <= accept ? strm.s_b  : 32'd0;
      fpu_op_q <= accept ? strm.s_op : 1'b0;
      vld_q    <= {vld_q[NS-2:0], accept};
      tag_q[0] <= accept ? strm.s_tag : '0;
      for (int i = 1; i < NS; i++) tag_q[i] <= tag_q[i-1];
      if (wr)  wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      ready_q    <= ready_d;
      flag_acc_q <= flag_acc_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (wr) begin
      res_mem[wptr_q]  <= fpu_result;
      flag_mem[wptr_q] <= fpu_flags;
      tag_mem[wptr_q]  <= tag_q[NS-1];
    end
  end

  assign fpu_a         = fpu_a_q;
  assign fpu_b         = fpu_b_q;
  assign fpu_operation = fpu_op_q;

  assign strm.s_ready  = ready_q;
  assign strm.m_valid  = head_valid;
  assign strm.m_result = head_valid ? res_mem[rptr_q] : 32'd0;
  assign strm.m_flags  = head_flags;
  assign strm.m_tag    = head_valid ? tag_mem[rptr_q] : '0;

  assign flag_acc  = flag_acc_q;
  assign occupancy = occ_q;

endmodule
